mbisr_repair_cam: RTL
=====================

MBISR_REPAIR_CAM -- requirements
Module: mbisr_repair_cam

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the memory word-address width (32 words).
REQ-002 Parameter NUM_SPARES, default 4, SHALL set the number of spare rows and repair entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 bist_start  input  1  SHALL be a one-cycle pulse from MBIST marking the start of a test run.
REQ-006 fail_valid  input  1  SHALL qualify fail_addr; one failing word per asserted cycle.
REQ-007 fail_addr  input  ADDR_W  SHALL be the failing word address reported by MBIST.
REQ-008 bist_done  input  1  SHALL be MBIST completion, level, sampled on the rising edge.
REQ-009 acc_valid, acc_addr  input  1, ADDR_W  SHALL be the functional access request and its logical address.
REQ-010 out_valid  output  1  SHALL qualify the remap result.
REQ-011 out_spare  output  1  SHALL be 1 when the access is redirected to a spare row.
REQ-012 out_idx  output  clog2(NUM_SPARES)  SHALL be the spare index when out_spare=1, else 0.
REQ-013 out_addr  output  ADDR_W  SHALL echo the logical address registered with the request.
REQ-014 repair_ok, repair_ovf  output  1, 1  SHALL be the final status: all faults repaired, or spare capacity exceeded.
REQ-015 used_cnt  output  clog2(NUM_SPARES+1)  SHALL be the number of allocated entries.

Function
REQ-016 FSM states SHALL be IDLE, CAPTURE, LOCKED and OVF.
REQ-017 IDLE->CAPTURE on bist_start: all entries invalidated, used_cnt=0, repair_ok=0, repair_ovf=0.
REQ-018 In CAPTURE, fail_valid with an address not already in the table SHALL allocate the lowest free entry and increment used_cnt in the same edge.
REQ-019 A fail_addr matching a valid entry (including one allocated in the previous cycle) SHALL NOT allocate or change used_cnt.
REQ-020 A new fail_valid with used_cnt==NUM_SPARES SHALL move the FSM to OVF and set repair_ovf=1; the table is kept unchanged.
REQ-021 CAPTURE->LOCKED on bist_done=1 with repair_ok=1; a fail_valid in that same cycle SHALL be captured first, so the cycle can end in OVF instead.
REQ-022 OVF SHALL ignore fail_valid and hold repair_ovf=1 and repair_ok=0 until the next bist_start or reset.
REQ-023 bist_start in any state SHALL restart per REQ-017, with priority over fail_valid and bist_done in the same cycle.
REQ-024 Remap SHALL have a latency of 1 cycle: out_* are registered from acc_* of the previous edge; out_valid = registered acc_valid.
REQ-025 Remap SHALL be active in LOCKED only; in every other state out_spare=0 and out_idx=0, with out_valid still following acc_valid.
REQ-026 Lookup SHALL be a fully-associative compare of acc_addr against the valid entries; at most one match exists by REQ-019.
REQ-027 used_cnt SHALL saturate at NUM_SPARES and SHALL never wrap.

Reset
REQ-028 On rst: FSM=IDLE; all entries invalid; out_valid, out_spare, out_idx, out_addr, repair_ok, repair_ovf and used_cnt all =0.
REQ-029 Reset asserted mid-CAPTURE SHALL discard the partial table; no status survives reset.

Configuration
REQ-030 With MBISR_SOFT_CLEAR_EN defined, input soft_clr (1 bit) SHALL invalidate the table and return the FSM to IDLE on the next edge, with lower priority than rst and higher priority than bist_start.
REQ-031 Without MBISR_SOFT_CLEAR_EN, the soft_clr port SHALL be absent, and the table is cleared only by rst or bist_start.

Structure
REQ-032 A shared package mbisr_pkg SHALL hold the FSM state enum, ADDR_W and NUM_SPARES defaults, and the entry struct {valid, addr}.
REQ-033 One sub-module, mbisr_cam_match, SHALL implement the combinational compare returning the hit flag and index; it SHALL be instantiated twice, once for fail_addr and once for acc_addr.

Verification
REQ-034 Stimulus: bist_start; fail 0x03 and 0x11; then bist_done. Required: LOCKED, used_cnt=2, repair_ok=1; acc 0x11 -> out_spare=1, out_idx=1 one cycle later.
REQ-035 Stimulus: fail 0x07 three times on consecutive cycles. Required: used_cnt=1, one entry only.
REQ-036 Stimulus: 5 distinct fails with NUM_SPARES=4. Required: repair_ovf=1 after the 5th; bist_done leaves OVF, repair_ok=0, and acc to a captured address gives out_spare=0.
REQ-037 Stimulus: fail 0x1F in the same cycle as bist_done. Required: entry captured, then LOCKED; acc 0x1F remapped.
REQ-038 Stimulus: rst pulse asserted mid-CAPTURE after 2 fails. Required: all outputs 0 asynchronously, before the next clock edge; new run starts with used_cnt=0.
REQ-039 Stimulus: acc 0x03 while in CAPTURE. Required: out_valid=1, out_spare=0.

Source files
------------

// File: rtl/mbisr_pkg.sv
// Shared types and defaults for the MBISR repair CAM: FSM state encoding and the CAM entry layout.
package mbisr_pkg;

    localparam int MBISR_ADDR_W     = 5;
    localparam int MBISR_NUM_SPARES = 4;
    // Entries store a zero-extended address so one struct serves every ADDR_W up to this width.
    localparam int MBISR_MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_OVF     = 2'd3
    } mbisr_state_e;

    typedef struct packed {
        logic                        valid;
        logic [MBISR_MAX_ADDR_W-1:0] addr;
    } mbisr_entry_t;

endpackage

// File: rtl/mbisr_cam_match.sv
// Fully-associative compare of one key against all repair entries; returns hit flag and lowest matching index.
module mbisr_cam_match
    import mbisr_pkg::*;
#(
    parameter int NUM_SPARES = MBISR_NUM_SPARES,
    parameter int IDX_W      = 2
) (
    input  mbisr_entry_t [NUM_SPARES-1:0] entries_i,
    input  logic [MBISR_MAX_ADDR_W-1:0]   key_i,
    output logic                          hit_o,
    output logic [IDX_W-1:0]              idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (!found && entries_i[i].valid && (entries_i[i].addr == key_i)) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/mbisr_repair_cam.sv
// MBISR repair CAM: captures MBIST fail addresses into spare-row entries, then remaps functional accesses.
// Optional feature: define MBISR_SOFT_CLEAR_EN to add the soft_clr input (table clear back to IDLE).
module mbisr_repair_cam
    import mbisr_pkg::*;
#(
    parameter  int ADDR_W     = MBISR_ADDR_W,
    parameter  int NUM_SPARES = MBISR_NUM_SPARES,
    localparam int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
    localparam int CNT_W      = $clog2(NUM_SPARES + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MBISR_SOFT_CLEAR_EN
    input  logic              soft_clr,
`endif
    input  logic              bist_start,
    input  logic              fail_valid,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic              bist_done,
    input  logic              acc_valid,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic              out_valid,
    output logic              out_spare,
    output logic [IDX_W-1:0]  out_idx,
    output logic [ADDR_W-1:0] out_addr,
    output logic              repair_ok,
    output logic              repair_ovf,
    output logic [CNT_W-1:0]  used_cnt
);

    mbisr_state_e                  state_q, state_d;
    mbisr_entry_t [NUM_SPARES-1:0] tbl_q, tbl_d;
    logic [CNT_W-1:0]              used_q, used_d;
    logic                          ok_q, ok_d;
    logic                          ovf_q, ovf_d;

    logic              out_valid_q;
    logic              out_spare_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [ADDR_W-1:0] out_addr_q;

    logic             fail_hit;
    logic [IDX_W-1:0] fail_idx_unused;
    logic             acc_hit;
    logic [IDX_W-1:0] acc_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             clr_soft;

`ifdef MBISR_SOFT_CLEAR_EN
    assign clr_soft = soft_clr;
`else
    assign clr_soft = 1'b0;
`endif

    mbisr_cam_match #(
        .NUM_SPARES (NUM_SPARES),
        .IDX_W      (IDX_W)
    ) u_fail_match (
        .entries_i (tbl_q),
        .key_i     (MBISR_MAX_ADDR_W'(fail_addr)),
        .hit_o     (fail_hit),
        .idx_o     (fail_idx_unused)
    );

    mbisr_cam_match #(
        .NUM_SPARES (NUM_SPARES),
        .IDX_W      (IDX_W)
    ) u_acc_match (
        .entries_i (tbl_q),
        .key_i     (MBISR_MAX_ADDR_W'(acc_addr)),
        .hit_o     (acc_hit),
        .idx_o     (acc_idx)
    );

    // Entries are only ever cleared as a whole, so the lowest invalid slot is the next allocation.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (!free_found && !tbl_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        used_d  = used_q;
        ok_d    = ok_q;
        ovf_d   = ovf_q;
        if (clr_soft) begin
            state_d = ST_IDLE;
            tbl_d   = '0;
            used_d  = '0;
            ok_d    = 1'b0;
            ovf_d   = 1'b0;
        end else if (bist_start) begin
            state_d = ST_CAPTURE;
            tbl_d   = '0;
            used_d  = '0;
            ok_d    = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            if (fail_valid && !fail_hit) begin
                if ((used_q == CNT_W'(NUM_SPARES)) || !free_found) begin
                    state_d = ST_OVF;
                    ovf_d   = 1'b1;
                end else begin
                    tbl_d[free_idx].valid = 1'b1;
                    tbl_d[free_idx].addr  = MBISR_MAX_ADDR_W'(fail_addr);
                    used_d                = used_q + CNT_W'(1);
                end
            end
            // A same-cycle fail is captured first; an overflow there pre-empts the lock.
            if (bist_done && (state_d == ST_CAPTURE)) begin
                state_d = ST_LOCKED;
                ok_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tbl_q       <= '0;
            used_q      <= '0;
            ok_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_spare_q <= 1'b0;
            out_idx_q   <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            used_q      <= used_d;
            ok_q        <= ok_d;
            ovf_q       <= ovf_d;
            out_valid_q <= acc_valid;
            out_addr_q  <= acc_addr;
            out_spare_q <= acc_valid && (state_q == ST_LOCKED) && acc_hit;
            out_idx_q   <= (acc_valid && (state_q == ST_LOCKED) && acc_hit) ? acc_idx : '0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_spare  = out_spare_q;
    assign out_idx    = out_idx_q;
    assign out_addr   = out_addr_q;
    assign repair_ok  = ok_q;
    assign repair_ovf = ovf_q;
    assign used_cnt   = used_q;

endmodule
